// File: rtl/debounce_edge.sv
// debounce_edge: per-bit conditioner for slow asynchronous inputs.
// Each bit runs through a two-flop synchronizer, then a stability counter
// with a two-state FSM, and finally produces registered rise/fall strobes.
// Bits are fully independent.
//
// Parameters:
//   WIDTH - number of independent input bits
//   INIT  - reset value of the synchronizer flops and of o
//   COUNT - consecutive stable cycles required before o changes (1..65535)
//
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   i    - raw asynchronous inputs
//   o    - debounced levels
//   rise - one-cycle strobe when o goes 0->1
//   fall - one-cycle strobe when o goes 1->0
//   ack  - per-bit clear for evt (synchronous)
//   evt  - sticky "edge seen" flags
//
// Optional feature macro: DEBOUNCE_EVENT_LATCH_EN
//   defined   : evt latches on rise/fall, cleared by ack, set wins over ack
//   undefined : evt tied to 0, ack ignored, no flops generated
module debounce_edge #(
    parameter int               WIDTH = 1,
    parameter logic [WIDTH-1:0] INIT  = '0,
    parameter int               COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    input  logic [WIDTH-1:0] ack,
    output logic [WIDTH-1:0] evt
);

    localparam int CW = $clog2(COUNT + 1);
    // PENDING exits on the edge where the counter would reach COUNT.
    localparam logic [CW-1:0] CNT_LAST = CW'(COUNT - 1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= INIT;
            sync2_q <= INIT;
        end else begin
            sync1_q <= i;
            sync2_q <= sync1_q;
        end
    end

    for (genvar n = 0; n < WIDTH; n++) begin : g_bit
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          o_q, o_d;
        logic          rise_q, rise_d;
        logic          fall_q, fall_d;
        logic          s;

        assign s = sync2_q[n];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= ST_STABLE;
                cnt_q   <= '0;
                o_q     <= INIT[n];
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                o_q     <= o_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            o_d     = o_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            unique case (state_q)
                ST_STABLE: begin
                    if (s != o_q) begin
                        // With COUNT == 1 the first differing sample is
                        // already enough, so the level flips immediately.
                        if (COUNT == 1) begin
                            o_d    = s;
                            rise_d = s;
                            fall_d = ~s;
                        end else begin
                            state_d = ST_PENDING;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                ST_PENDING: begin
                    if (s == o_q) begin
                        // Bounce: discard the partial count.
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        o_d     = s;
                        rise_d  = s;
                        fall_d  = ~s;
                        cnt_d   = '0;
                        state_d = ST_STABLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            endcase
        end

        assign o[n]    = o_q;
        assign rise[n] = rise_q;
        assign fall[n] = fall_q;
    end

`ifdef DEBOUNCE_EVENT_LATCH_EN
    logic [WIDTH-1:0] evt_q;
    logic [WIDTH-1:0] evt_d;

    // A strobe visible in the same cycle as ack re-sets the flag, so an
    // acknowledge can never swallow a fresh edge.
    always_comb begin
        evt_d = (evt_q & ~ack) | rise | fall;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign evt = evt_q;
`else
    logic [WIDTH-1:0] unused_ack;
    assign unused_ack = ack;
    assign evt        = '0;
`endif

endmodule
